// File: rtl/control_pipe_pkg.sv
// rtl/control_pipe_pkg.sv - ctrl_pkg: opcode/funct constants, ALU and forwarding encodings, control bundle
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_b;
        logic       mem_write;
        logic       mem2reg;
        logic       branch;
        logic [2:0] alu_control;
    } ctrl_t;

    // Memory stage wins over Writeback; $0 is hardwired so it is never forwarded.
    function automatic fwd_sel_t fwd_select(input logic       reg_write_m,
                                            input logic [4:0] write_reg_m,
                                            input logic       reg_write_w,
                                            input logic [4:0] write_reg_w,
                                            input logic [4:0] src);
        if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == src) return FWD_MEM;
        if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == src) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// rtl/control_pipe_if.sv - decode-stage inputs and pipeline control outputs shared with dataPath
interface control_pipe_if;
    import ctrl_pkg::*;

    logic [5:0] opD;
    logic [5:0] functD;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rdD;
    logic       eqD;

    logic       regDstE;
    logic       aluSrcBE;
    logic [2:0] aluControlE;
    logic       memWriteM;
    logic       regWriteW;
    logic       mem2RegW;
    logic [4:0] writeRegE;
    logic [4:0] writeRegM;
    logic [4:0] writeRegW;
    logic       pcSrc;
    logic       stallF;
    logic       stallD;
    logic       flush;
    fwd_sel_t   fad;
    fwd_sel_t   fbd;

    modport master (
        output opD, functD, rsD, rtD, rdD, eqD,
        input  regDstE, aluSrcBE, aluControlE, memWriteM, regWriteW, mem2RegW,
               writeRegE, writeRegM, writeRegW, pcSrc, stallF, stallD, flush, fad, fbd
    );

    modport slave (
        input  opD, functD, rsD, rtD, rdD, eqD,
        output regDstE, aluSrcBE, aluControlE, memWriteM, regWriteW, mem2RegW,
               writeRegE, writeRegM, writeRegW, pcSrc, stallF, stallD, flush, fad, fbd
    );
endinterface

// File: rtl/control_pipe_main_decoder.sv
// rtl/control_pipe_main_decoder.sv - combinational opcode/funct to control bundle decode
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] opD,
    input  logic [5:0] functD,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opD)
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem2reg     = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (functD)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - pipelined control and hazard unit; CONTROL_PIPE_PERF_EN adds stall/flush counters
module control_pipe
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef CONTROL_PIPE_PERF_EN
    output logic [31:0]        stallCount,
    output logic [31:0]        flushCount,
`endif
    control_pipe_if.slave      cp
);

    ctrl_t ctrl_d;

    logic       reg_write_e, reg_dst_e, alu_src_b_e, mem_write_e, mem2reg_e;
    logic [2:0] alu_control_e;
    logic [4:0] rs_e, rt_e, rd_e;
    logic [4:0] write_reg_e;

    logic       reg_write_m, mem_write_m, mem2reg_m;
    logic [4:0] write_reg_m;

    logic       reg_write_w, mem2reg_w;
    logic [4:0] write_reg_w;

    logic load_use, branch_stall, stall;

    main_decoder u_main_decoder (
        .opD    (cp.opD),
        .functD (cp.functD),
        .ctrl   (ctrl_d)
    );

    assign write_reg_e = reg_dst_e ? rd_e : rt_e;

    assign load_use     = mem2reg_e && (rt_e == cp.rsD || rt_e == cp.rtD);
    // Branches compare in Decode, so a producer still in E, or a load still in M, must finish first.
    assign branch_stall = ctrl_d.branch &&
                          ((reg_write_e && (write_reg_e == cp.rsD || write_reg_e == cp.rtD)) ||
                           (mem2reg_m   && (write_reg_m == cp.rsD || write_reg_m == cp.rtD)));
    assign stall        = load_use | branch_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || stall) begin
            reg_write_e   <= 1'b0;
            reg_dst_e     <= 1'b0;
            alu_src_b_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            mem2reg_e     <= 1'b0;
            alu_control_e <= 3'b000;
            rs_e          <= 5'd0;
            rt_e          <= 5'd0;
            rd_e          <= 5'd0;
        end else begin
            reg_write_e   <= ctrl_d.reg_write;
            reg_dst_e     <= ctrl_d.reg_dst;
            alu_src_b_e   <= ctrl_d.alu_src_b;
            mem_write_e   <= ctrl_d.mem_write;
            mem2reg_e     <= ctrl_d.mem2reg;
            alu_control_e <= ctrl_d.alu_control;
            rs_e          <= cp.rsD;
            rt_e          <= cp.rtD;
            rd_e          <= cp.rdD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            mem2reg_m   <= 1'b0;
            write_reg_m <= 5'd0;
            reg_write_w <= 1'b0;
            mem2reg_w   <= 1'b0;
            write_reg_w <= 5'd0;
        end else begin
            reg_write_m <= reg_write_e;
            mem_write_m <= mem_write_e;
            mem2reg_m   <= mem2reg_e;
            write_reg_m <= write_reg_e;
            reg_write_w <= reg_write_m;
            mem2reg_w   <= mem2reg_m;
            write_reg_w <= write_reg_m;
        end
    end

    assign cp.regDstE     = reg_dst_e;
    assign cp.aluSrcBE    = alu_src_b_e;
    assign cp.aluControlE = alu_control_e;
    assign cp.writeRegE   = write_reg_e;
    assign cp.memWriteM   = mem_write_m;
    assign cp.writeRegM   = write_reg_m;
    assign cp.regWriteW   = reg_write_w;
    assign cp.mem2RegW    = mem2reg_w;
    assign cp.writeRegW   = write_reg_w;

    assign cp.stallF = stall;
    assign cp.stallD = stall;
    assign cp.flush  = stall;
    assign cp.pcSrc  = ctrl_d.branch & cp.eqD & ~stall;

    assign cp.fad = fwd_select(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rs_e);
    assign cp.fbd = fwd_select(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rt_e);

`ifdef CONTROL_PIPE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= 32'd0;
            flushCount <= 32'd0;
        end else begin
            if (stall)
                stallCount <= stallCount + 32'd1;
            if (cp.pcSrc)
                flushCount <= flushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - self-checking bench for control_pipe: decode table, hazard sequences, random stream vs model
module tb_control_pipe;

    localparam logic [5:0] T_R    = 6'h00;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2b;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_ADD  = 6'h20;
    localparam logic [5:0] T_SUB  = 6'h22;
    localparam logic [5:0] T_AND  = 6'h24;
    localparam logic [5:0] T_OR   = 6'h25;
    localparam logic [5:0] T_SLT  = 6'h2a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_pipe_if cp();
`ifdef CONTROL_PIPE_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    control_pipe dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CONTROL_PIPE_PERF_EN
        .stallCount (stall_count),
        .flushCount (flush_count),
`endif
        .cp         (cp)
    );

    int checks = 0;
    int errors = 0;

    // One in-flight instruction, described by what it does rather than by control wires.
    typedef struct packed {
        logic       wr;
        logic       load;
        logic       store;
        logic       rdst;
        logic       srcb;
        logic       br;
        logic [2:0] alu;
        logic [4:0] rs, rt, rd, dst;
    } minst_t;

    minst_t pe = '0, pm = '0, pw = '0;
    minst_t e_d;
    logic e_stall, e_pc;
    logic [1:0] e_fa, e_fb;

    logic [5:0] d_op, d_fn;
    logic [4:0] d_rs, d_rt, d_rd;
    logic d_eq;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdst;
        logic       srcb;
        logic [2:0] alu;
        logic       memw;
        logic       regw;
        logic       m2r;
        logic [4:0] wreg;
        string      name;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_d(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic eq);
        d_op = op; d_fn = fn; d_rs = rs; d_rt = rt; d_rd = rd; d_eq = eq;
        cp.opD = op; cp.functD = fn; cp.rsD = rs; cp.rtD = rt; cp.rdD = rd; cp.eqD = eq;
        #1;
    endtask

    function automatic minst_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        minst_t m = '0;
        case (op)
            T_LW:   begin m.wr = 1; m.load = 1; m.srcb = 1; m.alu = 3'b010; end
            T_SW:   begin m.store = 1; m.srcb = 1; m.alu = 3'b010; end
            T_ADDI: begin m.wr = 1; m.srcb = 1; m.alu = 3'b010; end
            T_BEQ:  begin m.br = 1; m.alu = 3'b110; end
            T_R: begin
                case (fn)
                    T_ADD: begin m.wr = 1; m.rdst = 1; m.alu = 3'b010; end
                    T_SUB: begin m.wr = 1; m.rdst = 1; m.alu = 3'b110; end
                    T_AND: begin m.wr = 1; m.rdst = 1; m.alu = 3'b000; end
                    T_OR:  begin m.wr = 1; m.rdst = 1; m.alu = 3'b001; end
                    T_SLT: begin m.wr = 1; m.rdst = 1; m.alu = 3'b111; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        m.rs = rs; m.rt = rt; m.rd = rd;
        m.dst = m.rdst ? rd : rt;
        return m;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (pm.wr && pm.dst != 5'd0 && pm.dst == r) return 2'b10;
        if (pw.wr && pw.dst != 5'd0 && pw.dst == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_eval();
        logic lu, bs;
        e_d = ref_decode(d_op, d_fn, d_rs, d_rt, d_rd);
        lu = pe.load && (pe.rt == d_rs || pe.rt == d_rt);
        bs = e_d.br && ((pe.wr && (pe.dst == d_rs || pe.dst == d_rt)) ||
                        (pm.load && (pm.dst == d_rs || pm.dst == d_rt)));
        e_stall = lu | bs;
        e_pc = e_d.br & d_eq & ~e_stall;
        e_fa = ref_fwd(pe.rs);
        e_fb = ref_fwd(pe.rt);
    endfunction

    function automatic logic [31:0] dut_pipe();
        return {9'b0, cp.regDstE, cp.aluSrcBE, cp.aluControlE, cp.writeRegE, cp.memWriteM,
                cp.writeRegM, cp.regWriteW, cp.mem2RegW, cp.writeRegW};
    endfunction

    function automatic logic [31:0] dut_haz();
        return {24'b0, cp.stallF, cp.stallD, cp.flush, cp.pcSrc, cp.fad, cp.fbd};
    endfunction

    task automatic check_model(input string tag);
        model_eval();
        chk({tag, " pipe"}, dut_pipe(),
            {9'b0, pe.rdst, pe.srcb, pe.alu, pe.dst, pm.store, pm.dst, pw.wr, pw.load, pw.dst});
        chk({tag, " hazard"}, dut_haz(), {24'b0, e_stall, e_stall, e_stall, e_pc, e_fa, e_fb});
    endtask

    task automatic tick();
        minst_t nd;
        model_eval();
        nd = e_stall ? minst_t'('0) : e_d;
        @(posedge clk);
        pw = pm; pm = pe; pe = nd;
        #1;
    endtask

    task automatic step(input string tag);
        check_model(tag);
        tick();
    endtask

    task automatic nops(input int n);
        set_d(T_R, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (n) step("nop");
    endtask

    task automatic rand_d();
        logic [5:0] op, fn;
        case ($urandom_range(0, 9))
            0: begin op = T_LW;   fn = 6'($urandom); end
            1: begin op = T_SW;   fn = 6'($urandom); end
            2: begin op = T_ADDI; fn = 6'($urandom); end
            3: begin op = T_BEQ;  fn = 6'($urandom); end
            4: begin op = T_R;    fn = T_ADD; end
            5: begin op = T_R;    fn = T_SUB; end
            6: begin op = T_R;    fn = T_AND; end
            7: begin op = T_R;    fn = T_OR;  end
            8: begin op = T_R;    fn = T_SLT; end
            default: begin op = 6'($urandom); fn = 6'($urandom); end
        endcase
        set_d(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        tbl[0]  = '{T_LW,   T_SUB, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 5'd2, "lw"};
        tbl[1]  = '{T_SW,   T_ADD, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 5'd2, "sw"};
        tbl[2]  = '{T_ADDI, 6'h00, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 5'd2, "addi"};
        tbl[3]  = '{T_BEQ,  6'h00, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 5'd2, "beq"};
        tbl[4]  = '{T_R,    T_ADD, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 5'd3, "add"};
        tbl[5]  = '{T_R,    T_SUB, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 5'd3, "sub"};
        tbl[6]  = '{T_R,    T_AND, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 5'd3, "and"};
        tbl[7]  = '{T_R,    T_OR,  1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 5'd3, "or"};
        tbl[8]  = '{T_R,    T_SLT, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 5'd3, "slt"};
        tbl[9]  = '{T_R,    6'h3f, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd2, "r_badfunct"};
        tbl[10] = '{6'h3f,  T_ADD, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd2, "op_unknown"};

        set_d(T_R, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b0;
        #2;
        chk("reset pipe", dut_pipe(), 32'd0);
        chk("reset hazard", dut_haz(), 32'd0);
`ifdef CONTROL_PIPE_PERF_EN
        chk("reset counters", stall_count | flush_count, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_d(tbl[i].op, tbl[i].fn, 5'd1, 5'd2, 5'd3, 1'b0);
            step("tbl_d");
            set_d(T_R, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
            chk({tbl[i].name, " E"}, {22'b0, cp.regDstE, cp.aluSrcBE, cp.aluControlE, cp.writeRegE},
                {22'b0, tbl[i].rdst, tbl[i].srcb, tbl[i].alu, tbl[i].wreg});
            step("tbl_e");
            chk({tbl[i].name, " M"}, {26'b0, cp.memWriteM, cp.writeRegM}, {26'b0, tbl[i].memw, tbl[i].wreg});
            step("tbl_m");
            chk({tbl[i].name, " W"}, {25'b0, cp.regWriteW, cp.mem2RegW, cp.writeRegW},
                {25'b0, tbl[i].regw, tbl[i].m2r, tbl[i].wreg});
            step("tbl_w");
        end

        // add $3,$1,$2 then sub $4,$3,$1: back to back, then with a NOP between
        nops(3);
        set_d(T_R, T_ADD, 5'd1, 5'd2, 5'd3, 1'b0); step("fa_add");
        set_d(T_R, T_SUB, 5'd3, 5'd1, 5'd4, 1'b0); step("fa_sub");
        chk("fwd mem fad", {30'b0, cp.fad}, 32'd2);
        nops(3);
        set_d(T_R, T_ADD, 5'd1, 5'd2, 5'd3, 1'b0); step("fw_add");
        nops(1);
        set_d(T_R, T_SUB, 5'd3, 5'd1, 5'd4, 1'b0); step("fw_sub");
        chk("fwd wb fad", {30'b0, cp.fad}, 32'd1);

        // lw $2,0($1) then add $3,$2,$2
        nops(3);
        set_d(T_LW, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); step("lu_lw");
        set_d(T_R, T_ADD, 5'd2, 5'd2, 5'd3, 1'b0);
        check_model("lu_stall");
        chk("load-use stall", {29'b0, cp.stallF, cp.stallD, cp.flush}, 32'd7);
        tick();
        chk("load-use release", {29'b0, cp.stallF, cp.stallD, cp.flush}, 32'd0);
        check_model("lu_release");
        tick();
        chk("load-use fwd", {28'b0, cp.fad, cp.fbd}, 32'b0101);

        // beq with and without a producer ahead of it
        nops(3);
        set_d(T_BEQ, 6'h00, 5'd1, 5'd1, 5'd0, 1'b1);
        chk("beq taken", {31'b0, cp.pcSrc}, 32'd1);
        step("beq");
        nops(3);
        set_d(T_R, T_ADD, 5'd4, 5'd5, 5'd1, 1'b0); step("bs_add");
        set_d(T_BEQ, 6'h00, 5'd1, 5'd1, 5'd0, 1'b1);
        chk("branch stall", {28'b0, cp.stallD, cp.flush, cp.stallF, cp.pcSrc}, 32'b1110);
        check_model("bs_stall");
        tick();
        chk("branch resume", {28'b0, cp.stallD, cp.flush, cp.stallF, cp.pcSrc}, 32'b0001);
        check_model("bs_resume");
        tick();
        nops(3);

        // random stream; Decode is held while the model predicts a stall
        rand_d();
        for (int i = 0; i < 400; i++) begin
            logic held;
            check_model("rand");
            held = e_stall;
            tick();
            if (!held) rand_d();
        end

        // reset asserted with the pipeline full
        set_d(T_R, T_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid reset pipe", dut_pipe(), 32'd0);
        chk("mid reset hazard", dut_haz(), 32'd0);
`ifdef CONTROL_PIPE_PERF_EN
        chk("mid reset counters", stall_count | flush_count, 32'd0);
`endif
        pe = '0; pm = '0; pw = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            set_d(T_LW, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); step("perf_lw");
            set_d(T_R, T_ADD, 5'd2, 5'd2, 5'd3, 1'b0); step("perf_stall"); step("perf_add");
            nops(3);
        end
        for (int i = 0; i < 2; i++) begin
            set_d(T_BEQ, 6'h00, 5'd1, 5'd1, 5'd0, 1'b1); step("perf_beq");
            nops(3);
        end
`ifdef CONTROL_PIPE_PERF_EN
        chk("stallCount", stall_count, 32'd3);
        chk("flushCount", flush_count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined control and hazard unit for the 32-bit pipelined processor. It decodes the instruction held in the Decode stage and carries the control bits through the Execute, Memory and Writeback pipeline registers. It also produces the stall, flush, branch-select and ALU forwarding selects that drive `dataPath`. It sits directly upstream of `dataPath` and replaces the hand-driven control inputs used today.

## Interface
- No parameters; register-address width fixed at 5, opcode/funct at 6.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `opD`  in  6  opcode of instruction in Decode
- `functD`  in  6  funct field in Decode
- `rsD`, `rtD`, `rdD`  in  5 each  register fields in Decode
- `eqD`  in  1  branch-compare equality from `dataPath`
- `regDstE`, `aluSrcBE`  out  1  Execute-stage controls
- `aluControlE`  out  3  ALU operation
- `memWriteM`  out  1  data-memory write
- `regWriteW`, `mem2RegW`  out  1  Writeback controls
- `writeRegE`, `writeRegM`, `writeRegW`  out  5  destination register per stage
- `pcSrc`  out  1  taken branch (Decode)
- `stallF`, `stallD`  out  1  hold PC / IF-ID register
- `flush`  out  1  bubble into ID/EX register
- `fad`, `fbd`  out  2  ALU operand A/B forwarding select

## Operation
- Decode (sub-module), producing {regWrite, regDst, aluSrcB, memWrite, mem2Reg, branch, aluControl}:
  - lw 100011: regWrite, mem2Reg, aluSrcB, aluControl=010
  - sw 101011: memWrite, aluSrcB, 010
  - addi 001000: regWrite, aluSrcB, 010
  - beq 000100: branch, 110
  - R-type 000000: regWrite, regDst. funct add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111. Any other funct → all zero.
  - Unknown opcode → all zero (NOP).
- E register: decoded bits plus rsD, rtD, rdD. M register and W register: the remaining bits plus writeReg. writeRegE = regDstE ? rdE : rtE.
- Load-use stall: mem2RegE && (rtE==rsD || rtE==rtD).
- Branch stall: branchD && ((regWriteE && writeRegE∈{rsD,rtD}) || (mem2RegM && writeRegM∈{rsD,rtD})).
- Stall outputs: stallF = stallD = flush = loadUse | branchStall.
- Branch select: pcSrc = branchD & eqD & ~stallD.
- fad select:
  - 10 if regWriteM && writeRegM≠0 && writeRegM==rsE
  - else 01 if regWriteW && writeRegW≠0 && writeRegW==rsE
  - else 00
  - fbd: identical rule against rtE. M takes priority over W.

## Timing
- Reset: all pipeline registers cleared asynchronously. Every registered output is 0, so the combinational outputs also evaluate to 0.
- Reset asserted mid-operation: the in-flight pipeline is discarded immediately.
- Latency: decode→E at the next edge, E→M one edge later, M→W one edge later.
- stallF, stallD, flush, pcSrc, fad and fbd are combinational, valid in the same cycle.
- flush=1: E loads all-zero at the next edge. M and W still advance.
- Stall: held for exactly 1 cycle per load-use. A branch stall lasts until the producer clears.
- Register $0: never forwarded, but still compared for stalls (harmless).
- Stall and taken branch together: the stall wins and pcSrc is 0.

## Configuration
- `CONTROL_PIPE_PERF_EN` defined: adds outputs `stallCount` and `flushCount` (32-bit each).
  - Both reset to 0.
  - stallCount increments on every cycle with stallD=1.
  - flushCount increments on every cycle with pcSrc=1.
  - Both wrap at 2^32.
- Undefined: the counters and ports are absent.

## Structure
- Package `ctrl_pkg`:
  - opcode and funct constants
  - aluControl encodings
  - fad/fbd encodings (FWD_NONE=00, FWD_WB=01, FWD_MEM=10)
  - packed control-bundle typedef
- Sub-module `main_decoder`: combinational opD/functD → control bundle.

## Test plan
- Reset low mid-stream → all outputs 0 in the same cycle.
- add $3,$1,$2 then sub $4,$3,$1 → while sub is in E, fad=10. With one NOP between them, fad=01.
- lw $2,0($1) then add $3,$2,$2 → stallF=stallD=flush=1 for one cycle, then fbd=01 and fad=01.
- beq $1,$1 with eqD=1, no hazard → pcSrc=1 in the Decode cycle. Preceded by add $1 → 1 stall, then pcSrc=1.
- Unknown opcode 111111 → E/M/W controls all 0, no writes.
- With `CONTROL_PIPE_PERF_EN`: 3 load-use pairs and 2 taken branches → stallCount=3, flushCount=2.
